alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage for three-register ALU instructions (ADD/SUB/MUL/DIV, r0 = r1 op r2) plus the instruction pointer.
//  Reads r1 and r2 from the register file, computes through an internal ALU and writes the result back to r0.
//  Pulses/holds finished for the CPU sequencer, and exposes ALU compare flags for branch units.
//  Also holds the 64-bit IP, which the CPU increments or loads at end of instruction.
// PARAMETERS
//  WIDTH     64  datapath / IP width
//  RID_W     4   register id width (16 registers)
//  IP_STEP   1   IP increment per inc pulse (word-addressed fetch)
//  RESET_IP  0   IP value after reset
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  enabled   in   1      start/hold request for one ALU instruction
//  op        in   2      0 ADD, 1 SUB, 2 MUL, 3 DIV
//  r0,r1,r2  in   RID_W  dest, src A, src B register ids
//  reg_out   in   WIDTH  regfile read data (valid 1 cycle after reg_re edge)
//  reg_id    out  RID_W  regfile address
//  reg_re    out  1      regfile read enable
//  reg_we    out  1      regfile write enable
//  reg_wd    out  WIDTH  regfile write data
//  finished  out  1      instruction done, write committed
//  alu_c     out  WIDTH  combinational ALU result of latched A,B,op
//  neg,pos,zero out 1   ALU flags of alu_c
//  ip_inc    in   1      advance IP by IP_STEP
//  ip_set    in   1      load IP from ip_val
//  ip_val    in   WIDTH  IP load value
//  ip        out  WIDTH  current instruction pointer
// BEHAVIOUR
//  - Reset: state IDLE; reg_id, reg_re, reg_we, reg_wd, finished, latched A/B/op = 0; ip = RESET_IP.
//  - rst mid-instruction aborts immediately; no regfile write occurs after rst is sampled.
//  - All control outputs are registered.
//  - FSM:
//    - IDLE: enabled=1 -> latch op, reg_id<=r1, reg_re<=1 -> RD_A.
//    - RD_A: reg_id<=r2 -> RD_B.
//    - RD_B: A<=reg_out -> CAP_B.
//    - CAP_B: B<=reg_out, reg_re<=0 -> WB.
//    - WB: reg_id<=r0, reg_wd<=alu_c, reg_we<=1 -> DONE.
//    - DONE: reg_we<=0, finished<=1. Holds while enabled=1; enabled=0 -> finished<=0 -> IDLE.
//  - Latency: finished high at the 6th rising edge after enabled is first sampled; reg_we high for exactly one cycle.
//  - enabled dropping before DONE: continue to completion (no abort).
//  - r0 may equal r1/r2; A and B are captured before the write.
//  - ALU (combinational, modulo 2^WIDTH, wraps silently):
//    - ADD a+b; SUB a-b; MUL low WIDTH bits of a*b; DIV unsigned a/b.
//    - DIV with b=0 yields all-ones.
//  - Flags: zero = (c==0); neg = c[WIDTH-1]; pos = !neg && !zero.
//  - IP: on each edge, ip_set has priority -> ip<=ip_val. Else ip_inc -> ip<=ip+IP_STEP, wrapping at 2^WIDTH. Else hold.
// CONFIGURATION
//  ALU_DIV_EN defined: DIV implemented as above.
//  ALU_DIV_EN undefined: op=3 yields c=0 (zero=1), no divider synthesized; FSM timing unchanged.
// STRUCTURE
//  Package alu_exec_pkg: op codes ALU_ADD/SUB/MUL/DIV, FSM state encoding, flag bit order.
//  Sub-module exec_alu: purely combinational op/a/b -> c, neg, pos, zero.
//  FSM and IP register are inline in alu_exec_unit.
// TESTING
//  - ADD, regs r1=5, r2=7, r0=3 -> one reg_we pulse with reg_id=3, reg_wd=12; finished after 6 edges.
//  - SUB 3-5 -> reg_wd=0xFFFF_FFFF_FFFF_FFFE, neg=1, pos=0, zero=0; SUB 9-9 -> zero=1.
//  - MUL 0x1_0000_0000*0x1_0000_0000 -> 0; DIV 100/7 -> 14; DIV x/0 -> all-ones (0 if ALU_DIV_EN off).
//  - rst asserted in RD_B -> no reg_we, finished=0, state IDLE next cycle.
//  - IP: inc x3 -> 3. set=1 with inc=1, ip_val=0x40 -> 0x40. ip=all-ones + inc -> 0.
//  - r0=r1=2, reg2=10: ADD r2,r2,r2 -> 20 written to reg 2.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execute unit: op codes, FSM states and flag layout.
// Optional divider is controlled by the ALU_DIV_EN macro (see exec_alu).
package alu_exec_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_CAP_B = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } exec_state_e;

    // Flag bit order, MSB first: neg, pos, zero.
    typedef struct packed {
        logic neg;
        logic pos;
        logic zero;
    } alu_flags_t;

    function automatic alu_flags_t alu_make_flags(input logic sign_bit, input logic is_zero);
        alu_flags_t f;
        f.neg  = sign_bit;
        f.zero = is_zero;
        f.pos  = !sign_bit && !is_zero;
        return f;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Purely combinational ALU: ADD/SUB/MUL/DIV modulo 2^WIDTH plus sign/zero flags.
// Macro ALU_DIV_EN enables the divider; without it op=DIV yields zero.
module exec_alu
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_c,
    output alu_flags_t       o_flags
);

    logic [WIDTH-1:0] w_c;

    // Result selection; MUL keeps only the low WIDTH bits of the product.
    always_comb begin
        w_c = '0;
        case (i_op)
            ALU_ADD: w_c = i_a + i_b;
            ALU_SUB: w_c = i_a - i_b;
            ALU_MUL: w_c = i_a * i_b;
            ALU_DIV: begin
`ifdef ALU_DIV_EN
                if (i_b == '0) begin
                    w_c = '1;
                end else begin
                    w_c = i_a / i_b;
                end
`else
                w_c = '0;
`endif
            end
            default: w_c = '0;
        endcase
    end

    assign o_c     = w_c;
    assign o_flags = alu_make_flags(w_c[WIDTH-1], (w_c == '0));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: reads r1/r2, computes via exec_alu, writes r0, and owns the IP register.
// Macro ALU_DIV_EN (consumed by exec_alu) selects whether DIV is implemented.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter int               RID_W    = 4,
    parameter logic [WIDTH-1:0] IP_STEP  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0] RESET_IP = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enabled,
    input  logic [1:0]       op,
    input  logic [RID_W-1:0] r0,
    input  logic [RID_W-1:0] r1,
    input  logic [RID_W-1:0] r2,
    input  logic [WIDTH-1:0] reg_out,
    output logic [RID_W-1:0] reg_id,
    output logic             reg_re,
    output logic             reg_we,
    output logic [WIDTH-1:0] reg_wd,
    output logic             finished,
    output logic [WIDTH-1:0] alu_c,
    output logic             neg,
    output logic             pos,
    output logic             zero,
    input  logic             ip_inc,
    input  logic             ip_set,
    input  logic [WIDTH-1:0] ip_val,
    output logic [WIDTH-1:0] ip
);

    exec_state_e      r_state;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [RID_W-1:0] r_reg_id;
    logic             r_reg_re;
    logic             r_reg_we;
    logic [WIDTH-1:0] r_reg_wd;
    logic             r_finished;
    logic [WIDTH-1:0] r_ip;
    logic [WIDTH-1:0] w_alu_c;
    alu_flags_t       w_flags;

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_c     (w_alu_c),
        .o_flags (w_flags)
    );

    // Instruction sequencer; regfile data arrives one cycle after the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= ALU_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_reg_id   <= '0;
            r_reg_re   <= 1'b0;
            r_reg_we   <= 1'b0;
            r_reg_wd   <= '0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enabled) begin
                        r_op     <= alu_op_e'(op);
                        r_reg_id <= r1;
                        r_reg_re <= 1'b1;
                        r_state  <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    r_reg_id <= r2;
                    r_state  <= ST_RD_B;
                end
                ST_RD_B: begin
                    r_a     <= reg_out;
                    r_state <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    r_b      <= reg_out;
                    r_reg_re <= 1'b0;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_reg_id <= r0;
                    r_reg_wd <= w_alu_c;
                    r_reg_we <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    // finished is always shown for at least one cycle, even if enabled dropped early.
                    r_reg_we <= 1'b0;
                    if (!r_finished) begin
                        r_finished <= 1'b1;
                    end else if (!enabled) begin
                        r_finished <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Instruction pointer: load beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ip <= RESET_IP;
        end else if (ip_set) begin
            r_ip <= ip_val;
        end else if (ip_inc) begin
            r_ip <= r_ip + IP_STEP;
        end
    end

    assign reg_id   = r_reg_id;
    assign reg_re   = r_reg_re;
    assign reg_we   = r_reg_we;
    assign reg_wd   = r_reg_wd;
    assign finished = r_finished;
    assign alu_c    = w_alu_c;
    assign neg      = w_flags.neg;
    assign pos      = w_flags.pos;
    assign zero     = w_flags.zero;
    assign ip       = r_ip;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit with a behavioural regfile and reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enabled;
    logic [1:0]  op;
    logic [3:0]  r0, r1, r2;
    logic [63:0] reg_out;
    logic [3:0]  reg_id;
    logic        reg_re, reg_we, finished, neg, pos, zero;
    logic [63:0] reg_wd, alu_c;
    logic        ip_inc, ip_set;
    logic [63:0] ip_val, ip;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  rid;
        logic [63:0] data;
        logic [2:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] regs [16];
    logic [63:0] model_regs [16];
    logic [63:0] model_ip;
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [63:0] pl_val;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .enabled(enabled), .op(op),
        .r0(r0), .r1(r1), .r2(r2), .reg_out(reg_out),
        .reg_id(reg_id), .reg_re(reg_re), .reg_we(reg_we), .reg_wd(reg_wd),
        .finished(finished), .alu_c(alu_c), .neg(neg), .pos(pos), .zero(zero),
        .ip_inc(ip_inc), .ip_set(ip_set), .ip_val(ip_val), .ip(ip)
    );

    // Behavioural register file with one-cycle read latency.
    always @(posedge clk) begin
        if (pl_en) regs[pl_idx] <= pl_val;
        else if (reg_we) regs[reg_id] <= reg_wd;
        if (reg_re) reg_out <= regs[reg_id];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        case (o)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                p = {64'd0, a} * {64'd0, b};
                return p[63:0];
            end
            default: begin
`ifdef ALU_DIV_EN
                if (b == 64'd0) return {64{1'b1}};
                return a / b;
`else
                return 64'd0;
`endif
            end
        endcase
    endfunction

    function automatic logic [2:0] ref_flags(input logic [63:0] c);
        logic n, z;
        n = c[63];
        z = (c == 64'd0);
        return {n, !n && !z, z};
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && reg_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: reg_id=%0d reg_wd=0x%016h with no pending instruction", reg_id, reg_wd);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_reg_id", {60'd0, reg_id}, {60'd0, mon_e.rid});
                check("wb_reg_wd", reg_wd, mon_e.data);
                check("wb_flags", {61'd0, neg, pos, zero}, {61'd0, mon_e.flags});
            end
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [63:0] val);
        model_regs[idx] = val;
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clk);
        #1;
        pl_en  = 1'b0;
    endtask

    task automatic run_instr(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s1,
                             input logic [3:0] s2, input bit early_drop);
        exp_t e;
        int   n;
        e.data  = ref_alu(o, model_regs[s1], model_regs[s2]);
        e.rid   = d;
        e.flags = ref_flags(e.data);
        exp_q.push_back(e);
        model_regs[d] = e.data;
        op = o; r0 = d; r1 = s1; r2 = s2;
        enabled = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && early_drop) enabled = 1'b0;
            if (finished) begin
                n = k;
                break;
            end
        end
        check("finish_latency", 64'(n), 64'd6);
        if (!early_drop) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                check("finished_hold", {63'd0, finished}, 64'd1);
            end
            enabled = 1'b0;
        end
        @(posedge clk);
        #1;
        check("finished_clear", {63'd0, finished}, 64'd0);
    endtask

    task automatic ip_step(input logic s, input logic i, input logic [63:0] v);
        ip_set = s; ip_inc = i; ip_val = v;
        if (s) model_ip = v;
        else if (i) model_ip = model_ip + 64'd1;
        @(posedge clk);
        #1;
        ip_set = 1'b0; ip_inc = 1'b0;
        check("ip", ip, model_ip);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enabled = 1'b0; op = 2'd0; r0 = 4'd0; r1 = 4'd0; r2 = 4'd0;
        ip_inc = 1'b0; ip_set = 1'b0; ip_val = 64'd0; pl_en = 1'b0; pl_idx = 4'd0; pl_val = 64'd0;
        model_ip = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_reg_id", {60'd0, reg_id}, 64'd0);
        check("rst_reg_re", {63'd0, reg_re}, 64'd0);
        check("rst_reg_we", {63'd0, reg_we}, 64'd0);
        check("rst_reg_wd", reg_wd, 64'd0);
        check("rst_finished", {63'd0, finished}, 64'd0);
        check("rst_alu_c", alu_c, 64'd0);
        check("rst_flags", {61'd0, neg, pos, zero}, 64'd1);
        check("rst_ip", ip, 64'd0);

        for (int i = 0; i < 16; i++) preload(4'(i), 64'd0);
        preload(4'd1, 64'd5);
        preload(4'd2, 64'd7);
        run_instr(2'd0, 4'd3, 4'd1, 4'd2, 1'b0);
        preload(4'd4, 64'd3);
        preload(4'd5, 64'd5);
        run_instr(2'd1, 4'd6, 4'd4, 4'd5, 1'b0);
        check("sub_neg_value", model_regs[6], 64'hFFFF_FFFF_FFFF_FFFE);
        preload(4'd4, 64'd9);
        preload(4'd5, 64'd9);
        run_instr(2'd1, 4'd6, 4'd4, 4'd5, 1'b1);
        preload(4'd7, 64'h1_0000_0000);
        run_instr(2'd2, 4'd8, 4'd7, 4'd7, 1'b0);
        preload(4'd9, 64'd100);
        preload(4'd10, 64'd7);
        preload(4'd11, 64'd0);
        run_instr(2'd3, 4'd12, 4'd9, 4'd10, 1'b0);
        run_instr(2'd3, 4'd13, 4'd9, 4'd11, 1'b1);
        preload(4'd2, 64'd10);
        run_instr(2'd0, 4'd2, 4'd2, 4'd2, 1'b0);
        check("self_add_value", model_regs[2], 64'd20);
        run_instr(2'd0, 4'd14, 4'd2, 4'd11, 1'b0);

        // Abort while in RD_B: no write may follow.
        op = 2'd0; r0 = 4'd15; r1 = 4'd1; r2 = 4'd2; enabled = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; enabled = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_finished", {63'd0, finished}, 64'd0);
        check("abort_reg_we", {63'd0, reg_we}, 64'd0);
        check("abort_reg_re", {63'd0, reg_re}, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_finish", {63'd0, finished}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) preload(4'(i), 64'($urandom_range(0, 20)));
            else preload(4'(i), {$urandom, $urandom});
        end
        for (int t = 0; t < 30; t++) begin
            run_instr(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        model_ip = 64'd0;
        repeat (3) ip_step(1'b0, 1'b1, 64'd0);
        check("ip_inc3", ip, 64'd3);
        ip_step(1'b1, 1'b1, 64'h40);
        check("ip_set_prio", ip, 64'h40);
        ip_step(1'b1, 1'b0, {64{1'b1}});
        ip_step(1'b0, 1'b1, 64'd0);
        check("ip_wrap", ip, 64'd0);
        ip_step(1'b0, 1'b0, 64'd99);
        for (int t = 0; t < 20; t++) begin
            ip_step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
